// File: rtl/trace_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | trace_buffer : run-trace capture FIFO with cycle stamp and stall watchdog  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module trace_buffer #(
  parameter int DEPTH   = 16,
  parameter int STATE_W = 5,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 63
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [STATE_W-1:0]              stateIn,
  input  logic                            wbWrite,
  input  logic [DATA_W-1:0]               wbData,
  input  logic                            rdEn,
  output logic [16+STATE_W+1+DATA_W-1:0]  rdData,
  output logic                            empty,
  output logic                            full,
  output logic [$clog2(DEPTH):0]          count,
  output logic                            overflow,
  output logic                            timeout,
  output logic [15:0]                     cycle
);
  localparam int            AW            = $clog2(DEPTH);
  localparam int            CW            = AW + 1;
  localparam int            ENTRY_W       = 16 + STATE_W + 1 + DATA_W;
  localparam logic [CW-1:0] FULL_COUNT    = DEPTH[CW-1:0];
  localparam logic [15:0]   TIMEOUT_LIMIT = TIMEOUT[15:0];

  localparam logic [0:0] S_RUN  = 1'b0;
  localparam logic [0:0] S_HALT = 1'b1;

  logic [0:0]         r_state;
  logic [STATE_W-1:0] r_prev_state;
  logic [15:0]        r_idle;
  logic [15:0]        r_cycle;
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic               r_overflow;
  logic               r_timeout;
  logic [ENTRY_W-1:0] r_mem [DEPTH];

  logic               w_run;
  logic               w_event;
  logic               w_pop;
  logic               w_push;
  logic               w_idle_trip;
  logic [DATA_W-1:0]  w_data;
  logic [15:0]        w_idle_next;

  assign w_run       = (r_state == S_RUN);
  assign w_event     = w_run && ((stateIn != r_prev_state) || wbWrite);
  assign w_pop       = rdEn && (r_count != '0);
  // A full FIFO still accepts a push when the head leaves on the same edge
  assign w_push      = w_event && ((r_count != FULL_COUNT) || w_pop);
  assign w_data      = wbWrite ? wbData : '0;
  assign w_idle_next = (r_idle < TIMEOUT_LIMIT) ? (r_idle + 16'd1) : r_idle;
  assign w_idle_trip = w_run && !w_event && (w_idle_next == TIMEOUT_LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_RUN;
      r_prev_state <= '0;
      r_idle       <= '0;
      r_cycle      <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_cycle <= r_cycle + 16'd1;
      if (w_run) begin
        r_prev_state <= stateIn;
      end
      if (w_event) begin
        r_idle <= '0;
      end else if (w_run) begin
        r_idle <= w_idle_next;
      end
      if (w_idle_trip) begin
        r_state   <= S_HALT;
        r_timeout <= 1'b1;
      end
      if (w_event && !w_push) begin
        r_overflow <= 1'b1;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // Storage needs no reset: the pointers alone define which entries are live
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {r_cycle, stateIn, wbWrite, w_data};
    end
  end

  assign rdData   = r_mem[r_rd_ptr];
  assign empty    = (r_count == '0);
  assign full     = (r_count == FULL_COUNT);
  assign count    = r_count;
  assign overflow = r_overflow;
  assign timeout  = r_timeout;
  assign cycle    = r_cycle;

endmodule
`default_nettype wire

// File: tb/tb_trace_buffer.sv
`default_nettype none
// tb_trace_buffer: vector table, directed corner sequences and a randomized run
// checked against a queue-based reference model.
module tb_trace_buffer;
  localparam int DEPTH   = 16;
  localparam int STATE_W = 5;
  localparam int DATA_W  = 64;
  localparam int TIMEOUT = 63;
  localparam int EW      = 16 + STATE_W + 1 + DATA_W;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [STATE_W-1:0] stateIn = '0;
  logic              wbWrite = 1'b0;
  logic [DATA_W-1:0] wbData = '0;
  logic              rdEn = 1'b0;
  logic [EW-1:0]     rdData;
  logic              empty;
  logic              full;
  logic [$clog2(DEPTH):0] count;
  logic              overflow;
  logic              timeout;
  logic [15:0]       cycle;

  trace_buffer #(
    .DEPTH(DEPTH), .STATE_W(STATE_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .stateIn(stateIn), .wbWrite(wbWrite),
    .wbData(wbData), .rdEn(rdEn), .rdData(rdData), .empty(empty),
    .full(full), .count(count), .overflow(overflow), .timeout(timeout),
    .cycle(cycle)
  );

  always #5 clk = ~clk;

  // Reference model
  logic [EW-1:0]      mq[$];
  logic [15:0]        m_cycle;
  int                 m_idle;
  logic [STATE_W-1:0] m_prev;
  logic               m_halt;
  logic               m_ovf;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_cycle = '0;
    m_idle  = 0;
    m_prev  = '0;
    m_halt  = 1'b0;
    m_ovf   = 1'b0;
  endtask

  task automatic model_step(input logic [STATE_W-1:0] st, input logic wb,
                            input logic [DATA_W-1:0] d, input logic rd);
    logic          evt;
    logic [EW-1:0] tmp;
    evt = !m_halt && ((st != m_prev) || wb);
    if (rd && mq.size() > 0) tmp = mq.pop_front();
    if (evt) begin
      if (mq.size() < DEPTH) mq.push_back({m_cycle, st, wb, (wb ? d : 64'd0)});
      else m_ovf = 1'b1;
    end
    if (!m_halt) m_prev = st;
    if (evt) m_idle = 0;
    else if (!m_halt) begin
      m_idle++;
      if (m_idle == TIMEOUT) m_halt = 1'b1;
    end
    m_cycle = m_cycle + 16'd1;
  endtask

  task automatic compare_all();
    chk("count", count, mq.size());
    chk("empty", empty, mq.size() == 0);
    chk("full", full, mq.size() == DEPTH);
    chk("overflow", overflow, m_ovf);
    chk("timeout", timeout, m_halt);
    chk("cycle", cycle, m_cycle);
    if (mq.size() > 0) chk("rdData", rdData, mq[0]);
  endtask

  task automatic step(input logic [STATE_W-1:0] st, input logic wb,
                      input logic [DATA_W-1:0] d, input logic rd);
    stateIn = st; wbWrite = wb; wbData = d; rdEn = rd;
    @(posedge clk);
    model_step(st, wb, d, rd);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    stateIn = '0; wbWrite = 1'b0; wbData = '0; rdEn = 1'b0;
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [STATE_W-1:0] st;
    logic               wb;
    logic [DATA_W-1:0]  d;
    logic               rd;
    int                 ecount;
    logic [EW-1:0]      ehead;
  } vec_t;

  function automatic logic [EW-1:0] ent(input logic [15:0] stamp, input logic [STATE_W-1:0] st,
                                        input logic wb, input logic [DATA_W-1:0] d);
    return {stamp, st, wb, d};
  endfunction

  function automatic vec_t mkv(input logic [STATE_W-1:0] st, input logic wb, input logic [DATA_W-1:0] d,
                               input logic rd, input int ec, input logic [EW-1:0] eh);
    vec_t v;
    v.st = st; v.wb = wb; v.d = d; v.rd = rd; v.ecount = ec; v.ehead = eh;
    return v;
  endfunction

  vec_t tbl[15];

  initial begin
    logic [DATA_W-1:0] dd;
    logic [DATA_W-1:0] rnd;
    int guard;
    dd = 64'hDEADBEEF_00000001;
    for (int i = 0; i < 5; i++) tbl[i] = mkv(0, 0, 0, 0, 0, '0);
    tbl[5]  = mkv(1, 0, 0,  0, 1, ent(16'd5, 1, 0, 0));
    tbl[6]  = mkv(2, 0, 0,  0, 2, ent(16'd5, 1, 0, 0));
    tbl[7]  = mkv(3, 0, 0,  0, 3, ent(16'd5, 1, 0, 0));
    tbl[8]  = mkv(3, 0, 0,  1, 2, ent(16'd6, 2, 0, 0));
    tbl[9]  = mkv(3, 0, 0,  1, 1, ent(16'd7, 3, 0, 0));
    tbl[10] = mkv(3, 0, 0,  1, 0, '0);
    tbl[11] = mkv(3, 0, 0,  1, 0, '0);
    tbl[12] = mkv(3, 1, dd, 0, 1, ent(16'd12, 3, 1, dd));
    tbl[13] = mkv(3, 0, dd, 0, 1, ent(16'd12, 3, 1, dd));
    tbl[14] = mkv(3, 0, dd, 1, 0, '0);

    // Reset values and state/write-back vectors
    do_reset();
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].st, tbl[i].wb, tbl[i].d, tbl[i].rd);
      chk("tbl_count", count, tbl[i].ecount);
      chk("tbl_empty", empty, tbl[i].ecount == 0);
      if (tbl[i].ecount > 0) chk("tbl_head", rdData, tbl[i].ehead);
    end

    // Watchdog trips after exactly TIMEOUT idle edges; HALT blocks captures
    do_reset();
    repeat (TIMEOUT - 1) step(0, 0, 0, 0);
    chk("wd_early", timeout, 0);
    step(0, 0, 0, 0);
    chk("wd_trip", timeout, 1);
    chk("wd_cycle", cycle, 63);
    chk("wd_empty", empty, 1);
    step(5, 1, 64'h55, 0);
    chk("halt_nocap", count, 0);

    // Event on the would-trip edge wins; pops still work in HALT
    do_reset();
    repeat (TIMEOUT - 1) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("race_tmo", timeout, 0);
    chk("race_cnt", count, 1);
    repeat (TIMEOUT - 1) step(1, 0, 0, 0);
    chk("race_early", timeout, 0);
    step(1, 0, 0, 0);
    chk("race_trip", timeout, 1);
    step(0, 0, 0, 1);
    chk("halt_pop", count, 0);

    // Overflow: 17 events into a 16-deep FIFO
    do_reset();
    for (int i = 0; i < 17; i++) step(STATE_W'(i + 1), 0, 0, 0);
    chk("ovf_full", full, 1);
    chk("ovf_cnt", count, 16);
    chk("ovf_flag", overflow, 1);
    for (int i = 0; i < 16; i++) step(17, 0, 0, 1);
    chk("ovf_drained", empty, 1);

    // 17th event with a simultaneous pop is not lost
    do_reset();
    for (int i = 0; i < 16; i++) step(STATE_W'(i + 1), 0, 0, 0);
    step(17, 0, 0, 1);
    chk("pp_ovf", overflow, 0);
    chk("pp_cnt", count, 16);

    // Pop while empty, then push/pop pairs across pointer wrap
    do_reset();
    step(0, 0, 0, 1);
    chk("empty_pop", count, 0);
    for (int i = 0; i < 40; i++) begin
      step(0, 1, 64'(i) | 64'hA5A5_0000_0000_0000, 1);
      chk("pair_cnt", count, 1);
    end

    // Randomized traffic: fill-heavy phase then drain-heavy phase
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rnd = {$urandom, $urandom};
      step(STATE_W'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0), rnd,
           (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
    end

    // Asynchronous reset mid-stream with count=7, cycle=0x0123
    do_reset();
    guard = 0;
    while (m_cycle != 16'h011D && guard < 1000) begin
      step(0, 1, {$urandom, $urandom}, 1);
      guard++;
    end
    repeat (6) step(0, 1, {$urandom, $urandom}, 0);
    chk("mid_cnt", count, 7);
    chk("mid_cycle", cycle, 16'h0123);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_empty", empty, 1);
    chk("ar_full", full, 0);
    chk("ar_cnt", count, 0);
    chk("ar_ovf", overflow, 0);
    chk("ar_tmo", timeout, 0);
    chk("ar_cycle", cycle, 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/trace_buffer.md
# trace_buffer

Run-trace capture stage sitting directly downstream of the multicycle RISC-V core (`principal`). Consumes the core's control-FSM state (`stateOut`) and register-bank write-back value every cycle and records an entry on each state change or write-back into a show-ahead FIFO. Also runs a free-running cycle stamp and a no-progress watchdog that freezes capture when the core stalls. The bench or a debug port drains the FIFO.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `STATE_W`, 5: control-state width.
- `DATA_W`, 64: write-back data width.
- `TIMEOUT`, 63: consecutive no-progress cycles that trip the watchdog; 1..65535.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `stateIn`  in  STATE_W  core control state (`stateOut`).
- `wbWrite`  in  1  register-bank write enable this cycle.
- `wbData`  in  DATA_W  write-back mux output.
- `rdEn`  in  1  pop request.
- `rdData`  out  16+STATE_W+1+DATA_W  head entry `{stamp[15:0], state, wbFlag, data}`.
- `empty`  out  1  FIFO empty.
- `full`  out  1  FIFO full.
- `count`  out  $clog2(DEPTH)+1  occupancy.
- `overflow`  out  1  sticky: an entry was dropped.
- `timeout`  out  1  sticky: watchdog tripped; capture halted.
- `cycle`  out  16  free-running cycle counter.

## Operation
- FSM states: RUN, HALT. Reset enters RUN. RUN→HALT when idle counter reaches `TIMEOUT`. HALT exits only via `reset`.
- `prevState` register: reset 0; loads `stateIn` every cycle in RUN.
- Capture event (RUN only): `stateIn != prevState` OR `wbWrite`. Entry = `{cycle, stateIn, wbWrite, wbWrite ? wbData : 0}`.
- Push: on capture event if `!full`, or if `full` and a pop is accepted in the same cycle. Otherwise drop entry and set `overflow`.
- Pop: `rdEn && !empty` advances head. `rdEn` when empty is ignored and has no side effects.
- Simultaneous push and pop at any occupancy: both happen and `count` is unchanged.
- `rdData` is the head entry, taken from registered storage (show-ahead). It is undefined while `empty`.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. `full` = (`count`==DEPTH), `empty` = (`count`==0).
- `cycle`: +1 every clock in both RUN and HALT. Wraps 0xFFFF→0x0000.
- Idle counter (16-bit): cleared on any capture event. Otherwise +1 per RUN cycle, saturating at `TIMEOUT`.
- `timeout` is set the cycle the FSM enters HALT. In HALT, no captures occur but pops continue normally.
- `overflow` and `timeout` clear only on `reset`.

## Timing
- Reset values: `empty`=1, `full`=0, `count`=0, `overflow`=0, `timeout`=0, `cycle`=0, FSM=RUN, `prevState`=0, idle=0, pointers=0.
- `reset` acts immediately (asynchronously) on assertion. A reset mid-capture discards all stored entries.
- Capture latency is 1 cycle. An event sampled at edge N updates `rdData`, `empty` and `count` after edge N, and `stamp` equals the `cycle` value before edge N.
- Pop takes effect at the edge. The next entry appears on `rdData` after that edge.
- Watchdog: with no events since the edge at which idle was cleared, `timeout` rises after exactly `TIMEOUT` further RUN edges.
- An event on the same edge the idle count would reach `TIMEOUT` wins: idle clears and the block does not halt.

## Test plan
- Reset then idle: hold `stateIn`=0 and `wbWrite`=0 → no entries. `timeout`=1 after edge 63 (`cycle`=63), `empty` stays 1.
- State sequence 0→1→2→3 on consecutive cycles starting at `cycle`=5 → 3 entries with stamps 5,6,7, states 1,2,3, `wbFlag`=0. Popping returns them in order, then `empty`=1.
- `wbWrite`=1 with `wbData`=0xDEADBEEF_00000001 and unchanged state → one entry with `wbFlag`=1 and that data. Same data with `wbWrite`=0 → no entry.
- 17 consecutive events with DEPTH=16 and no pops → `full`=1, `count`=16, `overflow`=1, and the 17th event is lost. With `rdEn`=1 in the 17th cycle instead: `overflow`=0, `count` stays 16.
- `rdEn` while empty → `count` stays 0 and no pointer movement. Then 40 push/pop pairs → pointers wrap and data order is preserved.
- Assert `reset` mid-stream with `count`=7 and `cycle`=0x0123 → all outputs return to reset values immediately, without waiting for a clock edge.
